// File: rtl/axi_burst_master.sv
// axi_burst_master: command-driven AXI4 burst master with a 32-bit beat buffer.
// One write (AW/W/B) or read (AR/R) burst in flight; done/err reported per command.
module axi_burst_master #(
    parameter int AXI_ID_WIDTH   = 1,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 8,
    parameter int BUF_DEPTH      = 256
) (
    input  logic                        ACLK,
    input  logic                        ARESET,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        cmd_write,
    input  logic [AXI_ADDR_WIDTH-3:0]   cmd_addr,
    input  logic [7:0]                  cmd_len,
    input  logic [1:0]                  cmd_burst,
    output logic                        done,
    output logic                        err,
    input  logic                        buf_we,
    input  logic [$clog2(BUF_DEPTH)-1:0] buf_addr,
    input  logic [AXI_DATA_WIDTH-1:0]   buf_wdata,
    output logic [AXI_DATA_WIDTH-1:0]   buf_rdata,
    output logic [AXI_ID_WIDTH-1:0]     AWID,
    output logic [AXI_ADDR_WIDTH-1:0]   AWADDR,
    output logic [7:0]                  AWLEN,
    output logic [2:0]                  AWSIZE,
    output logic [1:0]                  AWBURST,
    output logic                        AWVALID,
    input  logic                        AWREADY,
    output logic [AXI_DATA_WIDTH-1:0]   WDATA,
    output logic [AXI_DATA_WIDTH/8-1:0] WSTRB,
    output logic                        WLAST,
    output logic                        WVALID,
    input  logic                        WREADY,
    input  logic [AXI_ID_WIDTH-1:0]     BID,
    input  logic [1:0]                  BRESP,
    input  logic                        BVALID,
    output logic                        BREADY,
    output logic [AXI_ID_WIDTH-1:0]     ARID,
    output logic [AXI_ADDR_WIDTH-1:0]   ARADDR,
    output logic [7:0]                  ARLEN,
    output logic [2:0]                  ARSIZE,
    output logic [1:0]                  ARBURST,
    output logic                        ARVALID,
    input  logic                        ARREADY,
    input  logic [AXI_ID_WIDTH-1:0]     RID,
    input  logic [AXI_DATA_WIDTH-1:0]   RDATA,
    input  logic [1:0]                  RRESP,
    input  logic                        RLAST,
    input  logic                        RVALID,
    output logic                        RREADY
);

    localparam int BW = $clog2(BUF_DEPTH);
    localparam logic [1:0] BURST_WRAP = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_FIN
    } state_t;

    state_t                      state_q, state_d;
    logic [AXI_ADDR_WIDTH-3:0]   addr_q, addr_d;
    logic [7:0]                  len_q, len_d;
    logic [1:0]                  burst_q, burst_d;
    logic [8:0]                  beat_q, beat_d;
    logic                        err_q, err_d;
    logic [AXI_DATA_WIDTH-1:0]   rdata_q, rdata_d;

    logic [AXI_DATA_WIDTH-1:0]   mem [BUF_DEPTH];
    logic                        mem_we;
    logic [BW-1:0]               mem_waddr;
    logic [AXI_DATA_WIDTH-1:0]   mem_wdata;

    logic wrap_ok, last_beat, r_keep;
    logic unused_ids;

    assign unused_ids = ^{BID, RID};
    assign wrap_ok    = (cmd_len == 8'd2) || (cmd_len == 8'd4) ||
                        (cmd_len == 8'd8) || (cmd_len == 8'd16);
    assign last_beat  = (beat_q == {1'b0, len_q});
    // beats past the programmed length are consumed but never stored
    assign r_keep     = !beat_q[8] && (beat_q[7:0] <= len_q);
    assign err        = err_q;
    assign buf_rdata  = rdata_q;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            burst_q <= '0;
            beat_q  <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            burst_q <= burst_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge ACLK) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        burst_d = burst_q;
        beat_d  = beat_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: if (cmd_valid) begin
                addr_d  = cmd_addr;
                len_d   = cmd_len - 8'd1;
                burst_d = cmd_burst;
                beat_d  = '0;
                err_d   = 1'b0;
                if (cmd_burst == BURST_WRAP && !wrap_ok) begin
                    err_d   = 1'b1;
                    state_d = S_FIN;
                end else begin
                    state_d = cmd_write ? S_AW : S_AR;
                end
            end
            S_AW: if (AWREADY) state_d = S_W;
            S_W: if (WREADY) begin
                if (last_beat) state_d = S_B;
                else beat_d = beat_q + 9'd1;
            end
            S_B: if (BVALID) begin
                err_d   = err_q | (BRESP != 2'b00);
                state_d = S_FIN;
            end
            S_AR: if (ARREADY) state_d = S_R;
            S_R: if (RVALID) begin
                err_d = err_q | (RRESP != 2'b00) | (RLAST & !last_beat);
                if (RLAST) state_d = S_FIN;
                else if (!beat_q[8]) beat_d = beat_q + 9'd1;
            end
            S_FIN: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rdata_d   = mem[buf_addr];
        mem_we    = 1'b0;
        mem_waddr = buf_addr;
        mem_wdata = buf_wdata;
        if (state_q == S_R) begin
            mem_we    = RVALID && r_keep;
            mem_waddr = beat_q[BW-1:0];
            mem_wdata = RDATA;
        end else if (state_q == S_IDLE) begin
            mem_we = buf_we;
        end
    end

    always_comb begin
        cmd_ready = 1'b0;
        done      = 1'b0;
        AWID      = '0;
        AWADDR    = '0;
        AWLEN     = '0;
        AWSIZE    = '0;
        AWBURST   = '0;
        AWVALID   = 1'b0;
        WDATA     = '0;
        WSTRB     = '0;
        WLAST     = 1'b0;
        WVALID    = 1'b0;
        BREADY    = 1'b0;
        ARID      = '0;
        ARADDR    = '0;
        ARLEN     = '0;
        ARSIZE    = '0;
        ARBURST   = '0;
        ARVALID   = 1'b0;
        RREADY    = 1'b0;
        unique case (state_q)
            S_IDLE: cmd_ready = 1'b1;
            S_AW: begin
                AWVALID = 1'b1;
                AWADDR  = {addr_q, 2'b00};
                AWLEN   = len_q;
                AWSIZE  = 3'b010;
                AWBURST = burst_q;
            end
            S_W: begin
                WVALID = 1'b1;
                WDATA  = mem[beat_q[BW-1:0]];
                WSTRB  = '1;
                WLAST  = last_beat;
            end
            S_B: BREADY = 1'b1;
            S_AR: begin
                ARVALID = 1'b1;
                ARADDR  = {addr_q, 2'b00};
                ARLEN   = len_q;
                ARSIZE  = 3'b010;
                ARBURST = burst_q;
            end
            S_R: RREADY = 1'b1;
            S_FIN: done = 1'b1;
            default: ;
        endcase
    end

endmodule
